// File: rtl/mips_load_store_unit_if.sv
// Request/response and Avalon signal bundle for the MIPS load/store unit.
// master: CPU datapath plus memory side; slave: the load/store unit itself.
interface mips_load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_rt;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_rt, waitrequest, readdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               address, write, read, writedata, byteenable
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_rt, waitrequest, readdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
               address, write, read, writedata, byteenable
    );
endinterface

// File: rtl/mips_load_store_unit.sv
// MIPS memory-access stage: decodes one load/store per request, runs one Avalon
// access with waitrequest stalls and optional timeout, and returns the aligned/merged result.
module mips_load_store_unit #(
    parameter int unsigned TIMEOUT = 0
) (
    input logic                  clk,
    input logic                  reset,
    mips_load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] rt_q, rt_d;
    logic [31:0] address_q, address_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    logic [1:0]  req_k;
    logic        illegal;
    logic [3:0]  req_be;
    logic [31:0] req_bus_wdata;
    logic [3:0]  lwl_be, lwr_be;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [4:0]  lwl_shift, lwr_shift;
    logic [31:0] load_result;
    logic        timeout_hit;

    assign req_k = bus.req_addr[1:0];

    // LWL touches lanes 0..k, LWR touches lanes k..3
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lwl_be[gi] = (2'(gi) <= req_k);
            assign lwr_be[gi] = (2'(gi) >= req_k);
        end
    endgenerate

    always_comb begin
        illegal       = 1'b0;
        req_be        = 4'b1111;
        req_bus_wdata = 32'h0;
        case (bus.req_op)
            4'h0, 4'h4, 4'h8: req_be = 4'b0001 << req_k;
            4'h1, 4'h5, 4'h9: begin
                illegal = bus.req_addr[0];
                req_be  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            end
            4'h3, 4'hB:       illegal = |req_k;
            4'h2:             req_be = lwl_be;
            4'h6:             req_be = lwr_be;
            default:          illegal = 1'b1;
        endcase
        case (bus.req_op)
            4'h8:    req_bus_wdata = {4{bus.req_wdata[7:0]}};
            4'h9:    req_bus_wdata = {2{bus.req_wdata[15:0]}};
            4'hB:    req_bus_wdata = bus.req_wdata;
            default: req_bus_wdata = 32'h0;
        endcase
    end

    // 3-k equals ~k on two bits, so the LWL shift is 8*(~k)
    assign lane_byte = 8'(bus.readdata >> {k_q, 3'b000});
    assign lane_half = k_q[1] ? bus.readdata[31:16] : bus.readdata[15:0];
    assign lwl_shift = {~k_q, 3'b000};
    assign lwr_shift = {k_q, 3'b000};

    always_comb begin
        case (op_q)
            4'h0:    load_result = {{24{lane_byte[7]}}, lane_byte};
            4'h4:    load_result = {24'h0, lane_byte};
            4'h1:    load_result = {{16{lane_half[15]}}, lane_half};
            4'h5:    load_result = {16'h0, lane_half};
            4'h2:    load_result = (bus.readdata << lwl_shift)
                                 | (rt_q & ~(32'hFFFF_FFFF << lwl_shift));
            4'h6:    load_result = (bus.readdata >> lwr_shift)
                                 | (rt_q & ~(32'hFFFF_FFFF >> lwr_shift));
            default: load_result = bus.readdata;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        k_d         = k_q;
        rt_d        = rt_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        be_d        = be_q;
        rdata_d     = rdata_q;
        error_d     = error_q;
        wait_cnt_d  = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d       = bus.req_op;
                    k_d        = req_k;
                    rt_d       = bus.req_rt;
                    wait_cnt_d = 32'h0;
                    rdata_d    = 32'h0;
                    error_d    = illegal;
                    if (illegal) begin
                        state_d = S_RESP;
                    end else begin
                        address_d   = {bus.req_addr[31:2], 2'b00};
                        be_d        = req_be;
                        writedata_d = req_bus_wdata;
                        state_d     = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (!bus.waitrequest) begin
                    rdata_d = op_q[3] ? 32'h0 : load_result;
                    error_d = 1'b0;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    rdata_d = 32'h0;
                    error_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'h1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= 4'h0;
            k_q         <= 2'b00;
            rt_q        <= 32'h0;
            address_q   <= 32'h0;
            writedata_q <= 32'h0;
            be_q        <= 4'h0;
            rdata_q     <= 32'h0;
            error_q     <= 1'b0;
            wait_cnt_q  <= 32'h0;
        end else begin
            op_q        <= op_d;
            k_q         <= k_d;
            rt_q        <= rt_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            be_q        <= be_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        bus.req_ready  = (state_q == S_IDLE) && !reset;
        bus.read       = (state_q == S_BUS) && !op_q[3];
        bus.write      = (state_q == S_BUS) && op_q[3];
        bus.resp_valid = (state_q == S_RESP);
        bus.resp_rdata = rdata_q;
        bus.resp_error = error_q;
        bus.address    = address_q;
        bus.writedata  = writedata_q;
        bus.byteenable = be_q;
    end
endmodule

// File: tb/tb_mips_load_store_unit.sv
// Self-checking bench for mips_load_store_unit: directed spec cases, reset/RESP-cycle
// corner cases and randomized requests checked against an arithmetic reference model.
module tb_mips_load_store_unit;
    localparam int TO = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mips_load_store_unit_if ifc ();

    mips_load_store_unit #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_illegal(input logic [3:0] op, input logic [31:0] addr);
        case (op)
            4'h0, 4'h2, 4'h4, 4'h6, 4'h8: return 1'b0;
            4'h1, 4'h5, 4'h9:             return (addr % 2) != 0;
            4'h3, 4'hB:                   return (addr % 4) != 0;
            default:                      return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [3:0] op, input int k);
        int lo;
        int hi;
        logic [3:0] be;
        be = 4'h0;
        case (op)
            4'h0, 4'h4, 4'h8: begin lo = k; hi = k;     end
            4'h1, 4'h5, 4'h9: begin lo = k; hi = k + 1; end
            4'h2:             begin lo = 0; hi = k;     end
            4'h6:             begin lo = k; hi = 3;     end
            default:          begin lo = 0; hi = 3;     end
        endcase
        for (int i = 0; i < 4; i++) if (i >= lo && i <= hi) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] w);
        case (op)
            4'h8:    return (w & 32'hFF) * 32'h0101_0101;
            4'h9:    return (w & 32'hFFFF) * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_result(input logic [3:0] op, input int k,
                                                 input logic [31:0] rd, input logic [31:0] rt);
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] ones;
        int sh;
        b    = (rd >> (8 * k)) & 32'hFF;
        h    = (rd >> (8 * k)) & 32'hFFFF;
        ones = 32'hFFFF_FFFF;
        case (op)
            4'h0: return (b >= 32'd128) ? b - 32'd256 : b;
            4'h4: return b;
            4'h1: return (h >= 32'd32768) ? h - 32'd65536 : h;
            4'h5: return h;
            4'h3: return rd;
            4'h2: begin sh = 8 * (3 - k); return (rd << sh) | (rt & ~(ones << sh)); end
            4'h6: begin sh = 8 * k;       return (rd >> sh) | (rt & ~(ones >> sh)); end
            default: return 32'h0;
        endcase
    endfunction

    // Starts at a negedge with the unit idle; ends at a negedge with the unit idle again.
    task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rt, input logic [31:0] rd, input int nwait);
        bit          ill;
        bit          to_err;
        bit          is_store;
        int          k;
        int          bus_cycles;
        logic [31:0] exp_rdata;
        logic [31:0] got_rdata;
        logic        got_err;
        ill      = model_illegal(op, addr);
        k        = int'(addr % 4);
        is_store = (op >= 4'h8);
        to_err   = !ill && (nwait >= TO);
        chk("req_ready_idle", 32'(ifc.req_ready), 32'd1);
        ifc.req_valid   = 1'b1;
        ifc.req_op      = op;
        ifc.req_addr    = addr;
        ifc.req_wdata   = wdata;
        ifc.req_rt      = rt;
        ifc.waitrequest = 1'($urandom);
        ifc.readdata    = $urandom;
        @(posedge clk); @(negedge clk);
        ifc.req_valid = 1'b0;
        ifc.req_op    = 4'($urandom);
        ifc.req_addr  = $urandom;
        ifc.req_wdata = $urandom;
        ifc.req_rt    = $urandom;
        if (!ill) begin
            bus_cycles = to_err ? TO : nwait + 1;
            for (int c = 0; c < bus_cycles; c++) begin
                chk("bus_read", 32'(ifc.read), 32'(!is_store));
                chk("bus_write", 32'(ifc.write), 32'(is_store));
                chk("bus_address", ifc.address, addr & 32'hFFFF_FFFC);
                chk("bus_byteenable", 32'(ifc.byteenable), 32'(model_be(op, k)));
                if (is_store) chk("bus_writedata", ifc.writedata, model_wdata(op, wdata));
                chk("bus_no_resp", 32'(ifc.resp_valid), 32'd0);
                chk("bus_not_ready", 32'(ifc.req_ready), 32'd0);
                ifc.waitrequest = (c < nwait);
                ifc.readdata    = (c < nwait) ? $urandom : rd;
                @(posedge clk); @(negedge clk);
            end
        end
        ifc.waitrequest = 1'($urandom);
        ifc.readdata    = $urandom;
        exp_rdata = (ill || to_err || is_store) ? 32'h0 : model_result(op, k, rd, rt);
        got_rdata = ifc.resp_rdata;
        got_err   = ifc.resp_error;
        chk("resp_valid", 32'(ifc.resp_valid), 32'd1);
        chk("resp_error", 32'(got_err), 32'(ill || to_err));
        chk("resp_rdata", got_rdata, exp_rdata);
        chk("resp_no_read", 32'(ifc.read), 32'd0);
        chk("resp_no_write", 32'(ifc.write), 32'd0);
        chk("resp_not_ready", 32'(ifc.req_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("resp_one_cycle", 32'(ifc.resp_valid), 32'd0);
        $display("txn op=%h addr=%h wdata=%h rt=%h rd=%h wait=%0d -> rdata=%h err=%0d",
                 op, addr, wdata, rt, rd, nwait, got_rdata, got_err);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        ifc.req_valid   = 1'b0;
        ifc.req_op      = 4'h0;
        ifc.req_addr    = 32'h0;
        ifc.req_wdata   = 32'h0;
        ifc.req_rt      = 32'h0;
        ifc.waitrequest = 1'b0;
        ifc.readdata    = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(ifc.req_ready), 32'd0);
        chk("rst_read", 32'(ifc.read), 32'd0);
        chk("rst_write", 32'(ifc.write), 32'd0);
        chk("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
        chk("rst_resp_error", 32'(ifc.resp_error), 32'd0);
        chk("rst_address", ifc.address, 32'h0);
        chk("rst_writedata", ifc.writedata, 32'h0);
        chk("rst_byteenable", 32'(ifc.byteenable), 32'h0);
        chk("rst_resp_rdata", ifc.resp_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_txn(4'h3, 32'h0000_1000, 32'h0, 32'h0, 32'hDEAD_BEEF, 0);
        run_txn(4'h0, 32'h0000_1003, 32'h0, 32'h0, 32'h8011_2233, 0);
        run_txn(4'h4, 32'h0000_1003, 32'h0, 32'h0, 32'h8011_2233, 0);
        run_txn(4'h9, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 32'h0, 3);
        run_txn(4'h3, 32'h0000_1002, 32'h0, 32'h0, 32'h0, 0);
        run_txn(4'hC, 32'h0000_1000, 32'h0, 32'h0, 32'h0, 0);
        run_txn(4'h2, 32'h0000_1001, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0);
        run_txn(4'h6, 32'h0000_1001, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0);
        run_txn(4'h3, 32'h0000_1000, 32'h0, 32'h0, 32'h0, 50);

        // Reset in the middle of a stalled read
        ifc.req_valid   = 1'b1;
        ifc.req_op      = 4'h3;
        ifc.req_addr    = 32'h0000_3000;
        ifc.waitrequest = 1'b1;
        @(posedge clk); @(negedge clk);
        ifc.req_valid = 1'b0;
        chk("mid_rst_read_before", 32'(ifc.read), 32'd1);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("mid_rst_read_dropped", 32'(ifc.read), 32'd0);
        chk("mid_rst_no_resp", 32'(ifc.resp_valid), 32'd0);
        chk("mid_rst_ready_low", 32'(ifc.req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(ifc.req_ready), 32'd1);
        chk("post_rst_no_resp", 32'(ifc.resp_valid), 32'd0);
        $display("txn reset during BUS: read dropped, no response");

        // A request raised during RESP must wait for the following idle cycle
        ifc.req_valid = 1'b1;
        ifc.req_op    = 4'h7;
        ifc.req_addr  = 32'h0000_0010;
        @(posedge clk); @(negedge clk);
        chk("resp_cycle_valid", 32'(ifc.resp_valid), 32'd1);
        chk("resp_cycle_ready", 32'(ifc.req_ready), 32'd0);
        ifc.req_op      = 4'h3;
        ifc.req_addr    = 32'h0000_4000;
        ifc.waitrequest = 1'b0;
        ifc.readdata    = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        chk("held_req_idle_ready", 32'(ifc.req_ready), 32'd1);
        chk("held_req_idle_noread", 32'(ifc.read), 32'd0);
        @(posedge clk); @(negedge clk);
        ifc.req_valid = 1'b0;
        chk("held_req_bus_read", 32'(ifc.read), 32'd1);
        chk("held_req_bus_addr", ifc.address, 32'h0000_4000);
        @(posedge clk); @(negedge clk);
        chk("held_req_resp", 32'(ifc.resp_valid), 32'd1);
        chk("held_req_rdata", ifc.resp_rdata, 32'h1234_5678);
        chk("held_req_err", 32'(ifc.resp_error), 32'd0);
        @(posedge clk); @(negedge clk);
        $display("txn request held through RESP accepted in next IDLE cycle");

        for (int n = 0; n < 120; n++) begin
            logic [3:0]  op;
            logic [31:0] addr;
            int          nw;
            op   = 4'($urandom_range(0, 15));
            addr = $urandom;
            if ($urandom_range(0, 2) == 0) addr = addr & 32'hFFFF_FFFC;
            nw   = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            run_txn(op, addr, $urandom, $urandom, $urandom, nw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
